// File: rtl/lock_key_loader.sv
// lock_key_loader: receives a serial unlock key with a CRC-8 trailer and
// applies it atomically to the locked c432 core once the CRC matches.
// Repeated bad loads latch a lockout that zeroes the key until reset.
module lock_key_loader #(
    parameter int unsigned P_W      = 4,
    parameter int unsigned X_W      = 37,
    parameter int unsigned CRC_W    = 8,
    parameter int unsigned MAX_FAIL = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load_start,
    input  logic           key_valid,
    input  logic           key_bit,
    output logic           key_ready,
    output logic           busy,
    output logic [P_W-1:0] key_p,
    output logic [X_W-1:0] key_x,
    output logic           key_applied,
    output logic           key_err,
    output logic [1:0]     fail_cnt,
    output logic           lockout
);

    localparam int unsigned KW    = P_W + X_W;
    localparam int unsigned CNT_W = $clog2(KW);
    localparam logic [CRC_W-1:0] CRC_POLY = CRC_W'(8'h07);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_KEY,
        ST_SHIFT_CRC,
        ST_CHECK,
        ST_LOCKOUT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KW-1:0]    shadow_q, shadow_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] rx_crc_q, rx_crc_d;
    logic [P_W-1:0]   key_p_q, key_p_d;
    logic [X_W-1:0]   key_x_q, key_x_d;
    logic             key_applied_q, key_applied_d;
    logic             key_err_q, key_err_d;
    logic [1:0]       fail_cnt_q, fail_cnt_d;

    logic             shifting;
    logic             xfer;
    logic             crc_fb;
    logic [CRC_W-1:0] crc_next;
    logic [1:0]       fail_inc;

    // Handshake and serial CRC step for the incoming key bit
    always_comb begin
        shifting = (state_q == ST_SHIFT_KEY) || (state_q == ST_SHIFT_CRC);
        xfer     = key_valid && shifting;
        crc_fb   = crc_q[CRC_W-1] ^ key_bit;
        crc_next = {crc_q[CRC_W-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);
        fail_inc = fail_cnt_q + 2'(1);
    end

    // Next-state and datapath: the applied key only moves at a CHECK match or lockout entry
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        crc_d         = crc_q;
        rx_crc_d      = rx_crc_q;
        key_p_d       = key_p_q;
        key_x_d       = key_x_q;
        key_applied_d = key_applied_q;
        key_err_d     = key_err_q;
        fail_cnt_d    = fail_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d   = ST_SHIFT_KEY;
                    cnt_d     = '0;
                    shadow_d  = '0;
                    crc_d     = '0;
                    rx_crc_d  = '0;
                    key_err_d = 1'b0;
                end
            end
            ST_SHIFT_KEY: begin
                if (load_start) begin
                    cnt_d    = '0;
                    shadow_d = '0;
                    crc_d    = '0;
                    rx_crc_d = '0;
                end else if (xfer) begin
                    shadow_d = {shadow_q[KW-2:0], key_bit};
                    crc_d    = crc_next;
                    if (cnt_q == CNT_W'(KW - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_SHIFT_CRC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_SHIFT_CRC: begin
                if (load_start) begin
                    state_d  = ST_SHIFT_KEY;
                    cnt_d    = '0;
                    shadow_d = '0;
                    crc_d    = '0;
                    rx_crc_d = '0;
                end else if (xfer) begin
                    rx_crc_d = {rx_crc_q[CRC_W-2:0], key_bit};
                    if (cnt_q == CNT_W'(CRC_W - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (rx_crc_q == crc_q) begin
                    key_p_d       = shadow_q[KW-1:X_W];
                    key_x_d       = shadow_q[X_W-1:0];
                    key_applied_d = 1'b1;
                    key_err_d     = 1'b0;
                    fail_cnt_d    = '0;
                    state_d       = ST_IDLE;
                end else begin
                    key_err_d  = 1'b1;
                    fail_cnt_d = fail_inc;
                    if (fail_inc == 2'(MAX_FAIL)) begin
                        key_p_d       = '0;
                        key_x_d       = '0;
                        key_applied_d = 1'b0;
                        state_d       = ST_LOCKOUT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_LOCKOUT: begin
                key_p_d       = '0;
                key_x_d       = '0;
                key_applied_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any load in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            shadow_q      <= '0;
            crc_q         <= '0;
            rx_crc_q      <= '0;
            key_p_q       <= '0;
            key_x_q       <= '0;
            key_applied_q <= 1'b0;
            key_err_q     <= 1'b0;
            fail_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            crc_q         <= crc_d;
            rx_crc_q      <= rx_crc_d;
            key_p_q       <= key_p_d;
            key_x_q       <= key_x_d;
            key_applied_q <= key_applied_d;
            key_err_q     <= key_err_d;
            fail_cnt_q    <= fail_cnt_d;
        end
    end

    // Status outputs decode straight from the state register
    assign key_ready   = shifting;
    assign busy        = shifting || (state_q == ST_CHECK);
    assign lockout     = (state_q == ST_LOCKOUT);
    assign key_p       = key_p_q;
    assign key_x       = key_x_q;
    assign key_applied = key_applied_q;
    assign key_err     = key_err_q;
    assign fail_cnt    = fail_cnt_q;

endmodule

// File: tb/tb_lock_key_loader.sv
// Directed bench for lock_key_loader: vector table of whole loads plus
// hand sequences for abort/restart, lockout and asynchronous reset.
module tb_lock_key_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start;
    logic        key_valid;
    logic        key_bit;
    logic        key_ready;
    logic        busy;
    logic [3:0]  key_p;
    logic [36:0] key_x;
    logic        key_applied;
    logic        key_err;
    logic [1:0]  fail_cnt;
    logic        lockout;

    int errs   = 0;
    int checks = 0;

    lock_key_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .key_valid   (key_valid),
        .key_bit     (key_bit),
        .key_ready   (key_ready),
        .busy        (busy),
        .key_p       (key_p),
        .key_x       (key_x),
        .key_applied (key_applied),
        .key_err     (key_err),
        .fail_cnt    (fail_cnt),
        .lockout     (lockout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [40:0] key;
        logic [7:0]  crc;
        bit          gap;
        bit          ovl;
        logic [3:0]  e_p;
        logic [36:0] e_x;
        bit          e_app;
        bit          e_err;
        logic [1:0]  e_fc;
        bit          e_lock;
    } vec_t;

    vec_t vecs [9];

    // Reference CRC-8 (poly 0x07, init 0) over the 41 key bits, MSB first
    function automatic logic [7:0] crc8(input logic [40:0] k);
        logic [7:0] c = 8'h00;
        logic fb;
        for (int i = 40; i >= 0; i--) begin
            fb = c[7] ^ k[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic vec_t mk(input logic [40:0] k, input logic [7:0] c, input bit g, input bit o,
                                input logic [3:0] p, input logic [36:0] x, input bit a, input bit e,
                                input logic [1:0] f, input bit l);
        vec_t v;
        v.key = k; v.crc = c; v.gap = g; v.ovl = o;
        v.e_p = p; v.e_x = x; v.e_app = a; v.e_err = e; v.e_fc = f; v.e_lock = l;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive n bits of s (MSB first); with gap, key_valid idles every other cycle
    task automatic send(input logic [48:0] s, input int n, input bit gap);
        int i    = 48;
        int sent = 0;
        bit idle = gap;
        while (sent < n) begin
            if (idle) begin
                key_valid = 1'b0;
            end else begin
                key_valid = 1'b1;
                key_bit   = s[i];
                i--;
                sent++;
            end
            if (gap) idle = !idle;
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
        key_bit   = 1'b0;
    endtask

    // Full load; returns #1 after the edge of the final transfer
    task automatic load_key(input logic [40:0] k, input logic [7:0] c, input bit gap, input bit ovl);
        load_start = 1'b1;
        key_valid  = ovl;
        key_bit    = ovl;
        @(posedge clk); #1;
        load_start = 1'b0;
        key_valid  = 1'b0;
        send({k, c}, 49, gap);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [40:0] key_a;

    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        key_valid  = 1'b0;
        key_bit    = 1'b0;
        key_a      = {4'hA, 37'h0};

        vecs[0] = mk(41'h0, 8'h00, 0, 1, 4'h0, 37'h0, 1, 0, 2'd0, 0);
        vecs[1] = mk(41'h1, 8'h07, 0, 0, 4'h0, 37'h1, 1, 0, 2'd0, 0);
        vecs[2] = mk(41'h1, 8'h07, 1, 0, 4'h0, 37'h1, 1, 0, 2'd0, 0);
        vecs[3] = mk(41'h1, 8'h06, 0, 0, 4'h0, 37'h1, 1, 1, 2'd1, 0);
        vecs[4] = mk(41'h1, 8'h05, 1, 0, 4'h0, 37'h1, 1, 1, 2'd2, 0);
        vecs[5] = mk(key_a, crc8(key_a), 0, 0, 4'hA, 37'h0, 1, 0, 2'd0, 0);
        vecs[6] = mk(41'h0, 8'h01, 0, 0, 4'hA, 37'h0, 1, 1, 2'd1, 0);
        vecs[7] = mk(41'h0, 8'h02, 0, 0, 4'hA, 37'h0, 1, 1, 2'd2, 0);
        vecs[8] = mk(41'h0, 8'h03, 0, 0, 4'h0, 37'h0, 0, 1, 2'd3, 1);

        // Reset values
        #7;
        chk("rst_key_applied", 64'(key_applied), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_key_ready", 64'(key_ready), 64'd0);
        chk("rst_key_x", 64'(key_x), 64'd0);
        do_reset();
        chk("idle_fail_cnt", 64'(fail_cnt), 64'd0);
        chk("idle_lockout", 64'(lockout), 64'd0);

        // Table of whole loads: CHECK holds one cycle, outputs update at the next edge
        for (int v = 0; v < 9; v++) begin
            load_key(vecs[v].key, vecs[v].crc, vecs[v].gap, vecs[v].ovl);
            chk($sformatf("v%0d_busy_check", v), 64'(busy), 64'd1);
            chk($sformatf("v%0d_ready_check", v), 64'(key_ready), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_key_p", v), 64'(key_p), 64'(vecs[v].e_p));
            chk($sformatf("v%0d_key_x", v), 64'(key_x), 64'(vecs[v].e_x));
            chk($sformatf("v%0d_applied", v), 64'(key_applied), 64'(vecs[v].e_app));
            chk($sformatf("v%0d_key_err", v), 64'(key_err), 64'(vecs[v].e_err));
            chk($sformatf("v%0d_fail_cnt", v), 64'(fail_cnt), 64'(vecs[v].e_fc));
            chk($sformatf("v%0d_lockout", v), 64'(lockout), 64'(vecs[v].e_lock));
            chk($sformatf("v%0d_busy_done", v), 64'(busy), 64'(vecs[v].e_lock ? 1'b0 : 1'b0));
        end

        // Lockout ignores load_start; reset clears everything
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        @(posedge clk); #1;
        chk("lock_busy", 64'(busy), 64'd0);
        chk("lock_still", 64'(lockout), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("lock_rst_lockout", 64'(lockout), 64'd0);
        chk("lock_rst_fail_cnt", 64'(fail_cnt), 64'd0);
        chk("lock_rst_key_err", 64'(key_err), 64'd0);
        do_reset();

        // Abort mid-key after one failure, then complete a valid load
        load_key(41'h1, 8'h06, 0, 0);
        @(posedge clk); #1;
        chk("abort_pre_fc", 64'(fail_cnt), 64'd1);
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        send({41'h1FFFFFFFFFF, 8'hFF}, 20, 0);
        chk("abort_mid_busy", 64'(busy), 64'd1);
        load_key(key_a, crc8(key_a), 0, 0);
        chk("abort_after_fc", 64'(fail_cnt), 64'd1);
        @(posedge clk); #1;
        chk("abort_key_p", 64'(key_p), 64'hA);
        chk("abort_key_x", 64'(key_x), 64'd0);
        chk("abort_applied", 64'(key_applied), 64'd1);
        chk("abort_fc_cleared", 64'(fail_cnt), 64'd0);

        // Asynchronous reset in SHIFT_CRC, between clock edges
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
        send({41'h1, 8'h07}, 44, 0);
        chk("arst_pre_ready", 64'(key_ready), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_key_p", 64'(key_p), 64'd0);
        chk("arst_applied", 64'(key_applied), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_key_ready", 64'(key_ready), 64'd0);
        do_reset();
        chk("arst_idle_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
